// File: rtl/match_score_ctl.sv
// match_score_ctl: penalty-shootout scorekeeper that decides the match outcome for MULTI and SOLO play.
// Optional build macro SUDDEN_DEATH_EN: a 5/5 tie continues into sudden death instead of counting as a loss.
package game_pkg;
    typedef enum logic [2:0] {START, KEEPER, SHOOTER, WINNER, LOSER} g_state;
endpackage

module match_score_ctl
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  g_state     game_state,
    input  logic       solo_mode,
    input  logic       round_done,
    input  logic       goal,
    output logic       match_end,
    output logic       match_result,
    output logic       end_gk,
    output logic       end_sh,
    output logic [3:0] score_player,
    output logic [3:0] score_enemy,
    output logic [3:0] kicks_player,
    output logic [3:0] kicks_enemy
);
    typedef enum logic [1:0] {IDLE, PLAY, EVAL, DONE} state_t;

    state_t state, state_n;
    logic solo, last_gk, take_gk, take_sh, decided, win;
    logic reg_win, reg_loss, tie5, tie15, sd;
    logic [5:0] sp, se, kp, ke;

    // Widened copies so the "remaining kicks" sums cannot wrap
    assign sp = {2'b0, score_player};
    assign se = {2'b0, score_enemy};
    assign kp = {2'b0, kicks_player};
    assign ke = {2'b0, kicks_enemy};

    always_comb begin
        take_gk  = state == PLAY && round_done && game_state == KEEPER;
        take_sh  = state == PLAY && round_done && game_state == SHOOTER;
        reg_win  = kp <= 6'd5 && ke <= 6'd5 && sp > se + 6'd5 - ke;
        reg_loss = kp <= 6'd5 && ke <= 6'd5 && se > sp + 6'd5 - kp;
        tie5     = kp == 6'd5 && ke == 6'd5 && sp == se;
        tie15    = kp == 6'd15 && ke == 6'd15 && sp == se;
        sd       = kp == ke && kp > 6'd5 && sp != se;
`ifdef SUDDEN_DEATH_EN
        decided  = solo ? (se >= 6'd3 || ke >= se + 6'd3) : (reg_win || reg_loss || sd || tie15);
        win      = solo ? se < 6'd3 : (reg_win || (sd && sp > se));
`else
        decided  = solo ? (se >= 6'd3 || ke >= se + 6'd3) : (reg_win || reg_loss || tie5 || tie15);
        win      = solo ? se < 6'd3 : reg_win;
`endif
        state_n  = state;
        case (state)
            IDLE:    state_n = (game_state == KEEPER || game_state == SHOOTER) ? PLAY : IDLE;
            PLAY:    state_n = (take_gk || take_sh) ? EVAL : PLAY;
            EVAL:    state_n = decided ? DONE : PLAY;
            default: state_n = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || game_state == START) begin
            state        <= IDLE;
            solo         <= 1'b0;
            last_gk      <= 1'b0;
            match_end    <= 1'b0;
            match_result <= 1'b0;
            end_gk       <= 1'b0;
            end_sh       <= 1'b0;
            score_player <= '0;
            score_enemy  <= '0;
            kicks_player <= '0;
            kicks_enemy  <= '0;
        end else begin
            state  <= state_n;
            end_gk <= 1'b0;
            end_sh <= 1'b0;
            if (state == IDLE && state_n == PLAY)
                solo <= solo_mode;
            if (take_gk) begin
                kicks_enemy <= kicks_enemy + {3'b0, kicks_enemy != 4'd15};
                score_enemy <= score_enemy + {3'b0, goal && score_enemy != 4'd15};
                last_gk     <= 1'b1;
            end
            if (take_sh) begin
                kicks_player <= kicks_player + {3'b0, kicks_player != 4'd15};
                score_player <= score_player + {3'b0, goal && score_player != 4'd15};
                last_gk      <= 1'b0;
            end
            if (state == EVAL) begin
                match_end    <= decided;
                match_result <= decided && win;
                end_gk       <= !decided && last_gk;
                end_sh       <= !decided && !last_gk;
            end
        end
    end
endmodule

// File: tb/tb_match_score_ctl.sv
// tb_match_score_ctl: directed scenario checks for match_score_ctl.
module tb_match_score_ctl;
    import game_pkg::*;

    logic clk = 0, rst = 1, solo_mode = 0, round_done = 0, goal = 0;
    g_state game_state = START;
    logic match_end, match_result, end_gk, end_sh;
    logic [3:0] score_player, score_enemy, kicks_player, kicks_enemy;
    int passed = 0, total = 0;

    match_score_ctl dut (
        .clk(clk), .rst(rst), .game_state(game_state), .solo_mode(solo_mode),
        .round_done(round_done), .goal(goal), .match_end(match_end),
        .match_result(match_result), .end_gk(end_gk), .end_sh(end_sh),
        .score_player(score_player), .score_enemy(score_enemy),
        .kicks_player(kicks_player), .kicks_enemy(kicks_enemy)
    );

    always #5 clk = ~clk;

    task automatic start_match(input logic s);
        @(negedge clk); game_state = START; solo_mode = s;
        @(negedge clk); game_state = KEEPER;
    endtask

    // round_done in one cycle; returns at the sample point two cycles later
    task automatic kick(input g_state gs, input logic g);
        @(negedge clk); game_state = gs; round_done = 1; goal = g;
        @(negedge clk); round_done = 0; goal = 0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        total++; if ({match_end, match_result, end_gk, end_sh} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {match_end, match_result, end_gk, end_sh}); else passed++;
        total++; if ({score_player, score_enemy} !== 8'h0) $display("FAIL reset_scores: got %h exp 00", {score_player, score_enemy}); else passed++;
        total++; if ({kicks_player, kicks_enemy} !== 8'h0) $display("FAIL reset_kicks: got %h exp 00", {kicks_player, kicks_enemy}); else passed++;
        rst = 0;
    endtask

    task automatic test_multi_win;
        start_match(0);
        for (int i = 0; i < 6; i++) begin
            kick(i % 2 ? SHOOTER : KEEPER, i % 2 == 1);
            if (i < 5) begin
                total++; if (end_gk !== (i % 2 == 0) || end_sh !== (i % 2 == 1) || match_end !== 0) $display("FAIL win_pulse%0d: got gk=%b sh=%b end=%b exp gk=%b sh=%b end=0", i, end_gk, end_sh, match_end, i % 2 == 0, i % 2 == 1); else passed++;
            end
            if (i == 0) begin
                @(negedge clk);
                total++; if (end_gk !== 0) $display("FAIL pulse_width: got %b exp 0", end_gk); else passed++;
            end
        end
        total++; if (match_end !== 1 || match_result !== 1) $display("FAIL win_decide: got end=%b res=%b exp 1 1", match_end, match_result); else passed++;
        total++; if ({end_gk, end_sh} !== 2'b00) $display("FAIL win_no_pulse: got %b exp 00", {end_gk, end_sh}); else passed++;
        total++; if ({score_player, kicks_player, score_enemy, kicks_enemy} !== 16'h3303) $display("FAIL win_counts: got %h exp 3303", {score_player, kicks_player, score_enemy, kicks_enemy}); else passed++;
    endtask

    task automatic test_ignore;
        kick(SHOOTER, 1);
        total++; if (kicks_player !== 3 || score_player !== 3) $display("FAIL done_ignore: got k=%0d s=%0d exp 3 3", kicks_player, score_player); else passed++;
        total++; if (match_end !== 1 || match_result !== 1) $display("FAIL done_hold: got end=%b res=%b exp 1 1", match_end, match_result); else passed++;
        @(negedge clk); game_state = START;
        @(negedge clk);
        total++; if ({match_end, match_result, score_player, kicks_player} !== 10'h0) $display("FAIL start_clear: got %h exp 0", {match_end, match_result, score_player, kicks_player}); else passed++;
        start_match(0);
        @(negedge clk); round_done = 1; goal = 1; game_state = KEEPER;
        @(negedge clk);
        @(negedge clk); round_done = 0; goal = 0;
        total++; if (kicks_enemy !== 1 || score_enemy !== 1) $display("FAIL eval_ignore: got k=%0d s=%0d exp 1 1", kicks_enemy, score_enemy); else passed++;
        total++; if (end_gk !== 1) $display("FAIL eval_pulse: got %b exp 1", end_gk); else passed++;
    endtask

    task automatic test_tie;
        start_match(0);
        for (int i = 0; i < 10; i++) begin
            kick(i % 2 ? SHOOTER : KEEPER, i < 8);
            if (i < 9) begin
                total++; if (match_end !== 0) $display("FAIL tie_early%0d: got %b exp 0", i, match_end); else passed++;
            end
        end
        total++; if ({score_player, score_enemy, kicks_player, kicks_enemy} !== 16'h4455) $display("FAIL tie_counts: got %h exp 4455", {score_player, score_enemy, kicks_player, kicks_enemy}); else passed++;
`ifdef SUDDEN_DEATH_EN
        total++; if (match_end !== 0 || end_sh !== 1) $display("FAIL sd_continue: got end=%b sh=%b exp 0 1", match_end, end_sh); else passed++;
        kick(KEEPER, 0);
        total++; if (match_end !== 0 || end_gk !== 1) $display("FAIL sd_gk: got end=%b gk=%b exp 0 1", match_end, end_gk); else passed++;
        kick(SHOOTER, 1);
        total++; if (match_end !== 1 || match_result !== 1) $display("FAIL sd_win: got end=%b res=%b exp 1 1", match_end, match_result); else passed++;
`else
        total++; if (match_end !== 1 || match_result !== 0 || end_sh !== 0) $display("FAIL tie_loss: got end=%b res=%b sh=%b exp 1 0 0", match_end, match_result, end_sh); else passed++;
`endif
    endtask

    task automatic test_solo;
        start_match(1);
        for (int i = 0; i < 3; i++) begin
            kick(KEEPER, 1);
            if (i < 2) begin
                total++; if (match_end !== 0 || end_gk !== 1) $display("FAIL solo_goal%0d: got end=%b gk=%b exp 0 1", i, match_end, end_gk); else passed++;
            end
        end
        total++; if (match_end !== 1 || match_result !== 0) $display("FAIL solo_loss: got end=%b res=%b exp 1 0", match_end, match_result); else passed++;
        start_match(1);
        for (int i = 0; i < 3; i++) kick(KEEPER, 0);
        total++; if (match_end !== 1 || match_result !== 1) $display("FAIL solo_win: got end=%b res=%b exp 1 1", match_end, match_result); else passed++;
        total++; if (kicks_enemy !== 3 || score_enemy !== 0) $display("FAIL solo_counts: got k=%0d s=%0d exp 3 0", kicks_enemy, score_enemy); else passed++;
    endtask

    task automatic test_rst_eval;
        start_match(0);
        @(negedge clk); game_state = KEEPER; round_done = 1; goal = 1;
        @(negedge clk); round_done = 0; goal = 0; rst = 1;
        @(negedge clk); rst = 0;
        total++; if ({end_gk, end_sh, match_end} !== 3'b000) $display("FAIL rst_eval_pulse: got %b exp 000", {end_gk, end_sh, match_end}); else passed++;
        total++; if (kicks_enemy !== 0 || score_enemy !== 0) $display("FAIL rst_eval_counts: got k=%0d s=%0d exp 0 0", kicks_enemy, score_enemy); else passed++;
    endtask

    initial begin
        test_reset;
        test_multi_win;
        test_ignore;
        test_tie;
        test_solo;
        test_rst_eval;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
